// File: rtl/mmu_ptw.sv
// Sv32 page-table walker: bare/TLB-hit fast path, two-level walk with
// superpage support, TLB refill and a one-cycle response strobe.
module mmu_ptw (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] vaddr_i,
    input  logic [31:0] satp_i,
    output logic        busy_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_paddr_o,
    output logic        resp_fault_o,
    output logic [19:0] tlb_vpn_o,
    input  logic        tlb_hit_i,
    input  logic [31:0] tlb_entry_i,
    output logic        tlb_update_o,
    output logic [31:0] tlb_entry_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_err_i
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WALK1  = 3'd1;
    localparam logic [2:0] WALK0  = 3'd2;
    localparam logic [2:0] UPDATE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]  state;
    logic [19:0] vpn_q;
    logic [11:0] off_q;
    logic [31:0] paddr_q;
    logic        fault_q;

    logic        ack, lvl1, pte_bad, pte_leaf, walk_fault, descend;
    logic [31:0] leaf_entry;
    logic        unused_bits;

    // An ack only counts while our own request is outstanding.
    assign ack        = mem_ack_i & mem_req_o;
    assign lvl1       = (state == WALK1);
    assign pte_bad    = mem_err_i | ~mem_data_i[0] | (mem_data_i[2] & ~mem_data_i[1]);
    assign pte_leaf   = mem_data_i[1] | mem_data_i[3];
    assign walk_fault = pte_bad | (~pte_leaf & ~lvl1) | (pte_leaf & lvl1 & (|mem_data_i[19:10]));
    assign descend    = ~pte_bad & ~pte_leaf & lvl1;
    // Superpage leaves are refilled as 4 KiB entries carrying VPN0.
    assign leaf_entry = lvl1 ? {mem_data_i[31:20], vpn_q[9:0], mem_data_i[9:0]} : mem_data_i;

    assign busy_o       = (state != IDLE);
    assign resp_valid_o = (state == DONE);
    assign resp_fault_o = (state == DONE) & fault_q;
    assign resp_paddr_o = paddr_q;
    assign tlb_update_o = (state == UPDATE);
    assign tlb_vpn_o    = (state == IDLE) ? vaddr_i[31:12] : vpn_q;

    assign unused_bits = ^{satp_i[30:20], tlb_entry_i[31:30], tlb_entry_i[9:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            vpn_q       <= '0;
            off_q       <= '0;
            paddr_q     <= '0;
            fault_q     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            tlb_entry_o <= '0;
        end else begin
            case (state)
                IDLE: if (req_i) begin
                    vpn_q   <= vaddr_i[31:12];
                    off_q   <= vaddr_i[11:0];
                    fault_q <= 1'b0;
                    if (!satp_i[31]) begin
                        paddr_q <= vaddr_i;
                        state   <= DONE;
                    end else if (tlb_hit_i) begin
                        paddr_q <= {tlb_entry_i[29:10], vaddr_i[11:0]};
                        state   <= DONE;
                    end else begin
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= {satp_i[19:0], 12'h000} + {20'h0, vaddr_i[31:22], 2'b00};
                        state      <= WALK1;
                    end
                end
                WALK1, WALK0: begin
                    // WALK0 enters with the request low so it drops for a cycle after the L1 ack.
                    if (state == WALK0 && !mem_req_o) begin
                        mem_req_o <= 1'b1;
                    end else if (ack) begin
                        mem_req_o <= 1'b0;
                        if (walk_fault) begin
                            fault_q <= 1'b1;
                            paddr_q <= '0;
                            state   <= DONE;
                        end else if (descend) begin
                            mem_addr_o <= {mem_data_i[29:10], 12'h000} + {20'h0, vpn_q[9:0], 2'b00};
                            state      <= WALK0;
                        end else begin
                            tlb_entry_o <= leaf_entry;
                            state       <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    paddr_q <= {tlb_entry_o[29:10], off_q};
                    state   <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_ptw.sv
// Directed bench for mmu_ptw: a page-table model predicts each translation,
// a bus responder serves PTE reads, and one negedge monitor checks outputs.
module tb_mmu_ptw;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] vaddr_i, satp_i;
    logic        busy_o, resp_valid_o, resp_fault_o;
    logic [31:0] resp_paddr_o;
    logic [19:0] tlb_vpn_o;
    logic        tlb_hit_i;
    logic [31:0] tlb_entry_i;
    logic        tlb_update_o;
    logic [31:0] tlb_entry_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        mem_err_i;

    mmu_ptw dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .vaddr_i(vaddr_i), .satp_i(satp_i),
        .busy_o(busy_o), .resp_valid_o(resp_valid_o), .resp_paddr_o(resp_paddr_o),
        .resp_fault_o(resp_fault_o), .tlb_vpn_o(tlb_vpn_o), .tlb_hit_i(tlb_hit_i),
        .tlb_entry_i(tlb_entry_i), .tlb_update_o(tlb_update_o), .tlb_entry_o(tlb_entry_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i), .mem_err_i(mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    // Page-table memory and expected-result model state
    logic [31:0] pmem [logic [31:0]];
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] exp_reads [$];
    logic        exp_upd, exp_fault, exp_active = 1'b0, upd_seen = 1'b0;
    logic [19:0] exp_upd_vpn;
    logic [31:0] exp_upd_entry, exp_paddr, last_paddr, last_entry;
    int          lat = 1;
    int          ack_budget = 1000;
    logic        manual = 1'b0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return pmem.exists(a) ? pmem[a] : 32'h0;
    endfunction

    task automatic predict(input logic [31:0] va, input logic [31:0] sp,
                           input logic hit, input logic [31:0] ent);
        logic [31:0] base, a, pte;
        logic [9:0]  idx;
        exp_reads.delete();
        exp_upd = 1'b0; exp_fault = 1'b0; exp_paddr = 32'h0;
        exp_upd_vpn = va[31:12]; exp_upd_entry = 32'h0;
        if (!sp[31]) exp_paddr = va;
        else if (hit) exp_paddr = {ent[29:10], va[11:0]};
        else begin
            base = {sp[19:0], 12'h000};
            for (int lvl = 1; lvl >= 0; lvl--) begin
                idx = (lvl == 1) ? va[31:22] : va[21:12];
                a = base + {20'h0, idx, 2'b00};
                exp_reads.push_back(a);
                pte = rd(a);
                if (a == err_addr || !pte[0] || (pte[2] && !pte[1])) begin exp_fault = 1'b1; break; end
                if (!pte[1] && !pte[3]) begin
                    if (lvl == 0) begin exp_fault = 1'b1; break; end
                    base = {pte[29:10], 12'h000};
                    continue;
                end
                if (lvl == 1) begin
                    if (pte[19:10] != 10'h0) begin exp_fault = 1'b1; break; end
                    pte[19:10] = va[21:12];
                end
                exp_upd = 1'b1; exp_upd_entry = pte;
                exp_paddr = {pte[29:10], va[11:0]};
                break;
            end
        end
    endtask

    // Bus responder: acks after lat cycles of request, while budget lasts
    int cnt = 0;
    initial forever begin
        @(posedge clk_i); #1;
        if (!manual) begin
            if (mem_req_o && !mem_ack_i && ack_budget > 0) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = rd(mem_addr_o);
                    mem_err_i  = (mem_addr_o == err_addr);
                    cnt = 0;
                    ack_budget--;
                end
            end else begin
                mem_ack_i = 1'b0;
                mem_err_i = 1'b0;
                if (!mem_req_o) cnt = 0;
            end
        end
    end

    // Single output monitor
    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            if (mem_req_o) begin
                if (exp_reads.size() == 0) chk("mem_req_unexpected", 32'd1, 32'd0);
                else begin
                    chk("mem_addr", mem_addr_o, exp_reads[0]);
                    if (mem_ack_i) void'(exp_reads.pop_front());
                end
            end
            if (tlb_update_o) begin
                chk("tlb_update_expected", 32'd1, {31'h0, exp_upd});
                chk("tlb_vpn", {12'h0, tlb_vpn_o}, {12'h0, exp_upd_vpn});
                chk("tlb_entry", tlb_entry_o, exp_upd_entry);
                upd_seen = 1'b1;
                last_entry = tlb_entry_o;
            end
            if (resp_valid_o) begin
                chk("resp_in_txn", {31'h0, exp_active}, 32'd1);
                chk("resp_busy", {31'h0, busy_o}, 32'd1);
                chk("resp_fault", {31'h0, resp_fault_o}, {31'h0, exp_fault});
                chk("resp_paddr", resp_paddr_o, exp_paddr);
                chk("resp_update_seen", {31'h0, upd_seen}, {31'h0, exp_upd});
                chk("reads_left", exp_reads.size(), 32'd0);
                last_paddr = resp_paddr_o;
                upd_seen = 1'b0;
            end
        end
    end

    task automatic txn(input logic [31:0] va, input logic [31:0] sp,
                       input logic hit, input logic [31:0] ent, input int l);
        int cyc;
        logic got;
        predict(va, sp, hit, ent);
        lat = l;
        @(negedge clk_i);
        vaddr_i = va; satp_i = sp; tlb_hit_i = hit; tlb_entry_i = ent;
        req_i = 1'b1; exp_active = 1'b1;
        cyc = 0; got = 1'b0;
        while (cyc < 200 && !got) begin
            @(posedge clk_i); #1;
            cyc++;
            got = resp_valid_o;
        end
        req_i = 1'b0;
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
        if (!sp[31] || hit) chk("fast_latency", cyc, 32'd1);
        @(negedge clk_i); #1;
        exp_active = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; req_i = 1'b0; vaddr_i = 32'h0; satp_i = 32'h0;
        tlb_hit_i = 1'b0; tlb_entry_i = 32'h0;
        mem_ack_i = 1'b0; mem_data_i = 32'h0; mem_err_i = 1'b0;

        pmem[32'h0010_0004] = 32'h0008_0001;   // L1 -> table at 0x200000
        pmem[32'h0020_0004] = 32'h0000_400F;   // L0 leaf, PPN 0x10
        pmem[32'h0030_0004] = 32'h2000_000F;   // aligned superpage
        pmem[32'h0060_0004] = 32'h001C_0001;   // L1 -> table at 0x700000
        pmem[32'h0070_0004] = 32'h0000_0C01;   // non-leaf at level 0
        pmem[32'h0080_0004] = 32'h0000_040F;   // misaligned superpage
        pmem[32'h0090_0004] = 32'h0000_0005;   // W without R

        repeat (3) @(negedge clk_i);
        chk("rst_busy", {31'h0, busy_o}, 32'd0);
        chk("rst_mem_req", {31'h0, mem_req_o}, 32'd0);
        chk("rst_resp_valid", {31'h0, resp_valid_o}, 32'd0);
        chk("rst_resp_fault", {31'h0, resp_fault_o}, 32'd0);
        chk("rst_tlb_update", {31'h0, tlb_update_o}, 32'd0);
        chk("rst_paddr", resp_paddr_o, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_tlb_entry", tlb_entry_o, 32'h0);
        rst_i = 1'b1;

        txn(32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0, 1);
        chk("lit_bare", last_paddr, 32'h1234_5678);
        txn(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0004_8C01, 1);
        chk("lit_bare_max", last_paddr, 32'hFFFF_FFFF);
        // Hit paddr follows {entry[29:10], offset}
        txn(32'h1234_5678, 32'h8000_0100, 1'b1, 32'h0004_8C01, 1);
        chk("lit_hit", last_paddr, 32'h0012_3678);

        predict(32'h0040_1ABC, 32'h8000_0100, 1'b0, 32'h0);
        chk("model_l1_addr", exp_reads[0], 32'h0010_0004);
        chk("model_l0_addr", exp_reads[1], 32'h0020_0004);
        txn(32'h0040_1ABC, 32'h8000_0100, 1'b0, 32'h0, 2);
        chk("lit_walk_paddr", last_paddr, 32'h0001_0ABC);
        chk("lit_walk_entry", last_entry, 32'h0000_400F);

        txn(32'h0040_1ABC, 32'h8000_0300, 1'b0, 32'h0, 1);
        chk("lit_super_paddr", last_paddr, 32'h8000_1ABC);
        chk("lit_super_entry", last_entry, 32'h2000_040F);

        txn(32'h0040_1ABC, 32'h8000_0400, 1'b0, 32'h0, 1);   // V=0
        chk("lit_v0_paddr", last_paddr, 32'h0);
        err_addr = 32'h0050_0004;
        pmem[32'h0050_0004] = 32'h0008_0001;
        txn(32'h0040_1ABC, 32'h8000_0500, 1'b0, 32'h0, 3);   // bus error
        err_addr = 32'hFFFF_FFFF;
        txn(32'h0040_1ABC, 32'h8000_0600, 1'b0, 32'h0, 1);   // non-leaf at L0
        txn(32'h0040_1ABC, 32'h8000_0800, 1'b0, 32'h0, 1);   // misaligned superpage
        txn(32'h0040_1ABC, 32'h8000_0900, 1'b0, 32'h0, 2);   // W without R

        // Reset while WALK0 is waiting, then a stale ack
        predict(32'h0040_1ABC, 32'h8000_0100, 1'b0, 32'h0);
        ack_budget = 1; lat = 1;
        @(negedge clk_i);
        vaddr_i = 32'h0040_1ABC; satp_i = 32'h8000_0100; tlb_hit_i = 1'b0;
        req_i = 1'b1; exp_active = 1'b1;
        begin
            int w;
            w = 0;
            while (w < 50 && !(mem_req_o && mem_addr_o == 32'h0020_0004)) begin
                @(negedge clk_i);
                w++;
            end
            if (w >= 50) chk("walk0_wait_timeout", 32'd0, 32'd1);
        end
        rst_i = 1'b0;
        #1;
        chk("midwalk_rst_mem_req", {31'h0, mem_req_o}, 32'd0);
        chk("midwalk_rst_busy", {31'h0, busy_o}, 32'd0);
        chk("midwalk_rst_mem_addr", mem_addr_o, 32'h0);
        req_i = 1'b0; exp_active = 1'b0;
        exp_reads.delete();
        @(negedge clk_i);
        rst_i = 1'b1; ack_budget = 1000;
        manual = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'h0000_400F;
        @(negedge clk_i);
        mem_ack_i = 1'b0; manual = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("late_ack_no_resp", {31'h0, resp_valid_o}, 32'd0);
            chk("late_ack_idle", {31'h0, busy_o}, 32'd0);
        end

        txn(32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0, 1);
        chk("lit_post_rst_bare", last_paddr, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
